// File: rtl/data_display_if.sv
// Bus between the data counter stage and the seven-segment display driver.
// Data flows into the display; Segments/Digits flow out to the board pins.
interface data_display_if #(
  parameter int Size         = 4,
  parameter int NumberDigits = 4
);
  logic [Size-1:0]         Data;
  logic [7:0]              Segments;
  logic [NumberDigits-1:0] Digits;

  // Producer side: drives Data, observes the display pins
  modport master (output Data, input Segments, input Digits);
  // Display side: samples Data, drives the display pins
  modport slave  (input Data, output Segments, output Digits);
endinterface

// File: rtl/data_display.sv
// Multiplexed seven-segment display driver.
// A small FSM converts the sampled Data word to BCD by double-dabble and
// publishes the finished result into a display register; a prescaled scanner
// walks the digits and drives cathode/anode patterns from registers so that
// Segments and Digits always change on the same edge.
// The interface instance must be built with the same Size/NumberDigits.
module data_display #(
  parameter int    Size           = 4,
  parameter string Signed         = "No",
  parameter int    ClockPeriod_ns = 20,
  parameter int    DigitPeriod_ns = 1_000_000,
  parameter int    NumberDigits   = 4
) (
  input logic          Clock,
  input logic          nReset,
  data_display_if.slave bus
);

  localparam bit IsSigned  = (Signed == "Yes");
  // Decimal digits needed for any Size-bit magnitude: floor(Size*log10(2))+1
  localparam int BcdDigits = (Size * 30103) / 100000 + 1;
  localparam int BcdW      = 4 * BcdDigits;
  localparam int CntW      = $clog2(Size + 1);
  localparam int Ticks     = DigitPeriod_ns / ClockPeriod_ns;
  localparam int PreW      = (Ticks > 1) ? $clog2(Ticks) : 1;
  localparam int IdxW      = (NumberDigits > 1) ? $clog2(NumberDigits) : 1;

  localparam logic [6:0] SegMinus = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  // Reject configurations that cannot scan
  if (ClockPeriod_ns < 1 || DigitPeriod_ns < ClockPeriod_ns) begin : g_bad_period
    $error("data_display: DigitPeriod_ns must be >= ClockPeriod_ns >= 1");
  end
  if (NumberDigits < 1) begin : g_bad_digits
    $error("data_display: NumberDigits must be >= 1");
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SegBlank;
    endcase
  endfunction

  // ---------------------------------------------------------------- conversion
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [Size-1:0] mag_q;
  logic [BcdW-1:0] bcd_q;
  logic            neg_q;
  logic [CntW-1:0] cnt_q;
  logic [BcdW-1:0] disp_bcd_q;
  logic            disp_neg_q;

  // Two's complement negation; read as unsigned it also yields 2^(Size-1)
  // for the most negative input, so no extra magnitude bit is kept.
  logic [Size-1:0] data_neg;
  assign data_neg = (~bus.Data) + 1'b1;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  logic [BcdW-1:0] bcd_adj;
  for (genvar gi = 0; gi < BcdDigits; gi++) begin : g_dabble
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                            : bcd_q[4*gi +: 4];
  end

  // Conversion FSM: capture, shift Size bits through BCD, publish atomically
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= LOAD;
        LOAD: begin
          bcd_q <= '0;
          cnt_q <= '0;
          if (IsSigned && bus.Data[Size-1]) begin
            neg_q <= 1'b1;
            mag_q <= data_neg;
          end else begin
            neg_q <= 1'b0;
            mag_q <= bus.Data;
          end
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BcdW-2:0], mag_q[Size-1]};
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(Size - 1)) state_q <= DONE;
        end
        DONE: begin
          disp_bcd_q <= bcd_q;
          disp_neg_q <= neg_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- formatting
  int   msd;
  int   needed;
  logic overflow;

  // Locate the most significant non-zero digit and detect overflow
  always_comb begin
    msd = 0;
    for (int i = 0; i < BcdDigits; i++) begin
      if (disp_bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    needed   = msd + 1 + (disp_neg_q ? 1 : 0);
    overflow = (needed > NumberDigits);
  end

  logic [NumberDigits-1:0][6:0] digit_pat;
  for (genvar gi = 0; gi < NumberDigits; gi++) begin : g_digit
    if (gi < BcdDigits) begin : g_num
      assign digit_pat[gi] = overflow                      ? SegMinus :
                             (gi <= msd)                   ? seg7(disp_bcd_q[4*gi +: 4]) :
                             (disp_neg_q && gi == msd + 1) ? SegMinus : SegBlank;
    end else begin : g_pad
      assign digit_pat[gi] = overflow                      ? SegMinus :
                             (disp_neg_q && gi == msd + 1) ? SegMinus : SegBlank;
    end
  end

  // ---------------------------------------------------------------- scanning
  logic [PreW-1:0]         pre_q, pre_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [NumberDigits-1:0] dig_q, dig_d;
  logic [6:0]              cur_pat;

  // Pattern for the digit currently being scanned
  always_comb begin
    cur_pat = SegBlank;
    for (int i = 0; i < NumberDigits; i++) begin
      if (idx_q == IdxW'(i)) cur_pat = digit_pat[i];
    end
  end

  // Prescaler/index advance and the next anode/cathode pair
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PreW'(Ticks - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IdxW'(NumberDigits - 1)) ? '0 : idx_q + 1'b1;
    end
    seg_d = {1'b1, cur_pat};
    dig_d = ~(NumberDigits'(1) << idx_q);
  end

  // Scan state and output registers; reset blanks the display immediately
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= 8'hFF;
      dig_q <= '1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign bus.Segments = seg_q;
  assign bus.Digits   = dig_q;

endmodule

// File: tb/tb_data_display.sv
// Directed bench for data_display: four configurations share one clock and
// reset; every expected pattern below is written out by hand.
module tb_data_display;

  // Segment bytes {dp, g..a}
  localparam logic [7:0] P0 = 8'hC0, P1 = 8'hF9, P2 = 8'hA4, P3 = 8'hB0;
  localparam logic [7:0] P5 = 8'h92, P7 = 8'hF8, P8 = 8'h80, P9 = 8'h90;
  localparam logic [7:0] PM = 8'hBF, PB = 8'hFF;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #10 Clock = ~Clock;

  data_display_if #(.Size(4),  .NumberDigits(4)) if_u4  ();
  data_display_if #(.Size(4),  .NumberDigits(4)) if_s4  ();
  data_display_if #(.Size(8),  .NumberDigits(4)) if_u8  ();
  data_display_if #(.Size(16), .NumberDigits(4)) if_u16 ();

  data_display #(.Size(4), .Signed("No"), .ClockPeriod_ns(20), .DigitPeriod_ns(100),
                 .NumberDigits(4)) u_u4 (.Clock(Clock), .nReset(nReset), .bus(if_u4));
  data_display #(.Size(4), .Signed("Yes"), .ClockPeriod_ns(20), .DigitPeriod_ns(100),
                 .NumberDigits(4)) u_s4 (.Clock(Clock), .nReset(nReset), .bus(if_s4));
  data_display #(.Size(8), .Signed("No"), .ClockPeriod_ns(20), .DigitPeriod_ns(100),
                 .NumberDigits(4)) u_u8 (.Clock(Clock), .nReset(nReset), .bus(if_u8));
  data_display #(.Size(16), .Signed("No"), .ClockPeriod_ns(20), .DigitPeriod_ns(100),
                 .NumberDigits(4)) u_u16 (.Clock(Clock), .nReset(nReset), .bus(if_u16));

  function automatic logic [11:0] probe(input int inst);
    case (inst)
      0:       probe = {if_u4.Digits,  if_u4.Segments};
      1:       probe = {if_s4.Digits,  if_s4.Segments};
      2:       probe = {if_u8.Digits,  if_u8.Segments};
      3:       probe = {if_u16.Digits, if_u16.Segments};
      default: probe = 12'h000;
    endcase
  endfunction

  function automatic int active_digit(input logic [3:0] dg);
    case (dg)
      4'b1110: active_digit = 0;
      4'b1101: active_digit = 1;
      4'b1011: active_digit = 2;
      4'b0111: active_digit = 3;
      default: active_digit = -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Watch one full scan (4 digits x 5 cycles) and compare every digit shown
  task automatic check_frame(input int inst, input string tag, input logic [31:0] exp);
    logic [11:0] p;
    logic [3:0]  seen;
    int          k;
    seen = 4'h0;
    repeat (20) begin
      @(negedge Clock);
      p = probe(inst);
      k = active_digit(p[11:8]);
      check({tag, " onehot"}, (k >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (k >= 0) begin
        check($sformatf("%s digit%0d", tag, k), {24'h0, p[7:0]}, {24'h0, exp[8*k +: 8]});
        seen[k] = 1'b1;
      end
    end
    check({tag, " all digits scanned"}, {28'h0, seen}, 32'hF);
  endtask

  // During a transition every shown digit must belong to the old or new frame
  task automatic watch(input int inst, input string tag, input logic [31:0] old_f,
                       input logic [31:0] new_f, input int cycles);
    logic [11:0] p;
    int          k;
    logic        ok;
    repeat (cycles) begin
      @(negedge Clock);
      p  = probe(inst);
      k  = active_digit(p[11:8]);
      ok = (k >= 0) && ((p[7:0] == old_f[8*k +: 8]) || (p[7:0] == new_f[8*k +: 8]));
      check({tag, " no stray value"}, {31'h0, ok}, 32'd1);
    end
  endtask

  initial begin
    logic [11:0] p;
    logic [3:0]  seq [4];
    logic [3:0]  prev, cur;
    int          n;

    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset state with data already present
    if_u4.Data  = 4'd9;
    if_s4.Data  = 4'b1000;
    if_u8.Data  = 8'd255;
    if_u16.Data = 16'd12345;
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      p = probe(i);
      check($sformatf("reset outputs inst%0d", i), {20'h0, p}, {20'h0, 4'hF, 8'hFF});
    end

    // Release; scanning begins on the first edge at digit 0
    nReset = 1'b1;
    @(posedge Clock);
    #1;
    check("first scan digit", {28'h0, if_u8.Digits}, 32'h0000_000E);

    repeat (30) @(negedge Clock);
    check_frame(0, "u4 9",      {PB, PB, PB, P9});
    check_frame(1, "s4 -8",     {PB, PB, PM, P8});
    check_frame(2, "u8 255",    {PB, P2, P5, P5});
    check_frame(3, "u16 12345", {PM, PM, PM, PM});

    // Scan order and dwell: enter digit 0, then 8 steps of 5 cycles each
    n = 0;
    prev = if_u8.Digits;
    @(negedge Clock);
    while (!(prev != 4'b1110 && if_u8.Digits == 4'b1110) && n < 40) begin
      prev = if_u8.Digits;
      @(negedge Clock);
      n++;
    end
    check("scan sync within bound", (n < 40) ? 32'd1 : 32'd0, 32'd1);
    for (int t = 0; t < 8; t++) begin
      cur = if_u8.Digits;
      n = 0;
      do begin
        @(negedge Clock);
        n++;
      end while (if_u8.Digits == cur && n < 20);
      check($sformatf("dwell step%0d", t), n, 32'd5);
      check($sformatf("digit order step%0d", t), {28'h0, if_u8.Digits}, {28'h0, seq[t % 4]});
    end

    // 255 -> 0: only old or new frame visible, new frame within 2*(8+3) cycles
    if_u8.Data = 8'd0;
    watch(2, "u8 255->0", {PB, P2, P5, P5}, {PB, PB, PB, P0}, 22);
    check_frame(2, "u8 0", {PB, PB, PB, P0});

    // Second batch of directed values
    if_u4.Data  = 4'd15;
    if_s4.Data  = 4'd7;
    if_u8.Data  = 8'd123;
    if_u16.Data = 16'd9999;
    repeat (40) @(negedge Clock);
    check_frame(0, "u4 15",    {PB, PB, P1, P5});
    check_frame(1, "s4 7",     {PB, PB, PB, P7});
    check_frame(2, "u8 123",   {PB, P1, P2, P3});
    check_frame(3, "u16 9999", {P9, P9, P9, P9});

    if_u4.Data  = 4'd0;
    if_s4.Data  = 4'b1111;
    if_u16.Data = 16'd1000;
    repeat (40) @(negedge Clock);
    check_frame(0, "u4 0",     {PB, PB, PB, P0});
    check_frame(1, "s4 -1",    {PB, PB, PM, P1});
    check_frame(3, "u16 1000", {P1, P0, P0, P0});

    if_s4.Data = 4'd0;
    if_u8.Data = 8'd255;
    repeat (40) @(negedge Clock);
    check_frame(1, "s4 0",      {PB, PB, PB, P0});
    check_frame(2, "u8 255 re", {PB, P2, P5, P5});

    // Reset pulse, then abort again in the middle of SHIFT
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    repeat (5) @(posedge Clock);
    #3;
    nReset = 1'b0;
    #1;
    p = probe(2);
    check("async reset mid-shift", {20'h0, p}, {20'h0, 4'hF, 8'hFF});
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    p = probe(2);
    check("reset held", {20'h0, p}, {20'h0, 4'hF, 8'hFF});
    nReset = 1'b1;
    watch(2, "u8 after reset", {PB, PB, PB, P0}, {PB, P2, P5, P5}, 22);
    check_frame(2, "u8 redisplay", {PB, P2, P5, P5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_display.md
DATA_DISPLAY -- requirements
Module: data_display

Interface
REQ-001 Parameter Size, default 4, width of input Data.
REQ-002 Parameter Signed, default "No"; "Yes" means Data is two's complement.
REQ-003 Parameter ClockPeriod_ns, default 20, Clock period.
REQ-004 Parameter DigitPeriod_ns, default 1_000_000, dwell time per digit.
REQ-005 Parameter NumberDigits, default 4, count of seven-segment digits.
REQ-006 Clock  input  1  single system clock; all state on rising edge.
REQ-007 nReset  input  1  asynchronous, active-low reset.
REQ-008 Data  input  Size  value from the data counter stage; sampled, not assumed stable.
REQ-009 Segments  output  8  active-low cathodes: [6:0]=g..a, [7]=dp.
REQ-010 Digits  output  NumberDigits  active-low digit enables, one-hot-low; bit 0 = rightmost digit.

Function
REQ-011 Conversion FSM SHALL have states IDLE, LOAD, SHIFT, DONE: IDLE->LOAD unconditionally; LOAD->SHIFT; SHIFT repeats Size cycles, then ->DONE; DONE->IDLE.
REQ-012 LOAD SHALL capture Data; when Signed=="Yes" and Data[Size-1]=1, Negative=1 and magnitude = two's complement negation computed at Size+1 bits (-2^(Size-1) converts correctly); otherwise Negative=0, magnitude=Data.
REQ-013 SHIFT SHALL use double-dabble: add 3 to every BCD nibble >=5, then shift magnitude MSB into BCD, one bit per cycle.
REQ-014 DONE SHALL copy BCD result and Negative into the display register in one cycle; intermediate values never reach Segments.
REQ-015 Data-to-display latency SHALL be at most 2*(Size+3) cycles; Data changes during a conversion take effect in the next conversion.
REQ-016 Prescaler SHALL count 0..DigitPeriod_ns/ClockPeriod_ns-1 and wrap; at wrap, digit index increments, NumberDigits-1 wraps to 0.
REQ-017 Digits SHALL drive low only bit [index]; Segments SHALL show that digit's pattern in the same cycle (registered together, no ghosting skew).
REQ-018 Patterns (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, blank=1111111; dp always 1.
REQ-019 Leading-zero blanking: digits above the most significant non-zero digit SHALL be blank; digit 0 SHALL always show a numeral (value 0 shows "0").
REQ-020 When Negative=1, minus SHALL appear on the digit immediately left of the most significant displayed numeral.
REQ-021 Overflow: if required digits (plus 1 when Negative) exceed NumberDigits, every digit SHALL show minus.
REQ-022 Elaboration SHALL fail if DigitPeriod_ns < ClockPeriod_ns or NumberDigits < 1.

Reset
REQ-023 nReset low SHALL immediately force Segments=8'hFF, Digits all 1, FSM=IDLE, prescaler=0, index=0, display register=0, Negative=0.
REQ-024 After nReset deasserts, first LOAD SHALL occur on the second rising edge; scanning starts on the first edge with index 0.
REQ-025 nReset asserted mid-conversion or mid-scan SHALL abort without any partial value displayed.

Verification
REQ-026 Size=4, Signed="No", Data=9 -> digit0 0010000, digits1-3 1111111.
REQ-027 Size=4, Signed="Yes", Data=4'b1000 -> digit0 0000000 ("8"), digit1 0111111, digits2-3 blank.
REQ-028 Size=8, Signed="No", Data=255 -> digits2..0 = 0100100, 0010010, 0010010; digit3 blank; Data 255->0 -> only "0" within 2*(Size+3) cycles, no other values.
REQ-029 DigitPeriod_ns=100, ClockPeriod_ns=20 -> index advances every 5 cycles, Digits 1110->1101->1011->0111->1110.
REQ-030 Size=16, Signed="No", NumberDigits=4, Data=12345 -> all four digits 0111111 (overflow).
REQ-031 nReset pulsed low mid-SHIFT -> Segments=8'hFF, Digits=4'b1111 same cycle, asynchronously; correct value redisplayed within 2*(Size+3) cycles after release.
